// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with busy scoreboard.
// Provides default sizes, the read-port index type and the zero-address helper.
package regfile_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

    localparam int MAX_READ   = 4;
    localparam int ADDR_MAX_W = 16;

    typedef logic [$clog2(MAX_READ)-1:0] rport_idx_t;

    // Callers widen their address to ADDR_MAX_W before the call.
    function automatic logic addr_is_zero(
        input logic [ADDR_MAX_W-1:0] addr
    );
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register check, write-back bypass, readiness.
// Ports: rd_addr/rd_stored/rd_busy in, fwd_en/wb_addr/wb_data in, rd_data/rd_ready out.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int AW       = DEF_AW,
    parameter int FORWARD  = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_stored,
    input  logic            rd_busy,
    input  logic            fwd_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_ready
);

    logic is_zero;
    logic fwd_hit;

    assign is_zero = (ZERO_REG != 0)
                   && addr_is_zero(ADDR_MAX_W'(rd_addr));

    // Zero register outranks the bypass, so the hit is made exclusive.
    assign fwd_hit = (FORWARD != 0) && fwd_en
                   && (wb_addr == rd_addr) && !is_zero;

    always_comb begin
        rd_data  = rd_stored;
        rd_ready = ~rd_busy;
        unique case (1'b1)
            is_zero: begin
                rd_data  = '0;
                rd_ready = 1'b1;
            end
            fwd_hit: begin
                rd_data  = wb_data;
                rd_ready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NUM_READ read ports, one write-back port and a busy scoreboard.
// Ports: clock/reset, rs_addr->rs_data/rs_ready, wb_*, issue_*, flush, busy_vec.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_READ = 2,
    parameter int FORWARD  = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_READ*AW-1:0]   rs_addr,
    output logic [NUM_READ*XLEN-1:0] rs_data,
    output logic [NUM_READ-1:0]      rs_ready,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy_vec
);

    localparam logic ZR = 1'(ZERO_REG != 0);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] iss_mask;
    logic                wb_blk;
    logic                iss_ok;
    logic                fwd_en;

    assign wb_blk = ZR && addr_is_zero(ADDR_MAX_W'(wb_addr));
    assign iss_ok = issue_en
                  && !(ZR && addr_is_zero(ADDR_MAX_W'(issue_addr)));

    // Bypass is gated off in reset so reads return the cleared state.
    assign fwd_en = wb_en & ~reset;

    always_comb begin
        wb_mask  = '0;
        iss_mask = '0;
        if (wb_en)
            wb_mask[wb_addr] = 1'b1;
        if (iss_ok)
            iss_mask[issue_addr] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (wb_en && !wb_blk) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Issue is OR'd in after the write-back clear: the write-back
    // belongs to the older instruction, so the new issue wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= (busy & ~wb_mask) | iss_mask;
    end

    assign busy_vec = busy;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[p*AW +: AW];

        regfile_read_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .FORWARD  (FORWARD),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .rd_addr   (a),
            .rd_stored (regs[a]),
            .rd_busy   (busy[a]),
            .fwd_en    (fwd_en),
            .wb_addr   (wb_addr),
            .wb_data   (wb_data),
            .rd_data   (rs_data[p*XLEN +: XLEN]),
            .rd_ready  (rs_ready[p])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus random bench for regfile_scoreboard, with and without bypass.
// Reference model is a plain array of values and busy flags.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] rs_addr;
    logic [NRD*XLEN-1:0] rs_data, rs_data_nf;
    logic [NRD-1:0]    rs_ready, rs_ready_nf;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic              flush;
    logic [NR-1:0]     busy_vec, busy_vec_nf;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] m_reg [NR];
    logic [NR-1:0]   m_busy;

    always #5 clock = ~clock;

    regfile_scoreboard #(
        .XLEN(XLEN), .NUM_REGS(NR), .NUM_READ(NRD),
        .FORWARD(1), .ZERO_REG(1)
    ) u_dut (
        .clock(clock), .reset(reset),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_ready(rs_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .flush(flush), .busy_vec(busy_vec)
    );

    regfile_scoreboard #(
        .XLEN(XLEN), .NUM_REGS(NR), .NUM_READ(NRD),
        .FORWARD(0), .ZERO_REG(1)
    ) u_nofwd (
        .clock(clock), .reset(reset),
        .rs_addr(rs_addr), .rs_data(rs_data_nf), .rs_ready(rs_ready_nf),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .flush(flush), .busy_vec(busy_vec_nf)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_reg[r] = '0;
        m_busy = '0;
    endtask

    function automatic void exp_read(input logic [AW-1:0] a, input bit fwd,
                                     output logic [XLEN-1:0] d, output logic r);
        if (reset || a == 0) begin
            d = '0; r = 1'b1;
        end else if (fwd && wb_en && wb_addr == a) begin
            d = wb_data; r = 1'b1;
        end else begin
            d = m_reg[a]; r = !m_busy[a];
        end
    endfunction

    task automatic check_reads(input string tag);
        logic [AW-1:0] a;
        logic [XLEN-1:0] d;
        logic r;
        for (int p = 0; p < NRD; p++) begin
            a = rs_addr[p*AW +: AW];
            exp_read(a, 1'b1, d, r);
            chk($sformatf("%s_fd%0d", tag, p), 64'(rs_data[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("%s_fr%0d", tag, p), 64'(rs_ready[p]), 64'(r));
            exp_read(a, 1'b0, d, r);
            chk($sformatf("%s_nd%0d", tag, p), 64'(rs_data_nf[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("%s_nr%0d", tag, p), 64'(rs_ready_nf[p]), 64'(r));
        end
    endtask

    // Edge semantics straight from the rules: store, then clear on
    // write-back, then set on issue so a same-cycle issue wins.
    task automatic tick(input string tag);
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
            if (flush) begin
                m_busy = '0;
            end else begin
                if (wb_en) m_busy[wb_addr] = 1'b0;
                if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            end
        end
        #1;
        chk({tag, "_busy"}, 64'(busy_vec), 64'(m_busy));
        chk({tag, "_busynf"}, 64'(busy_vec_nf), 64'(m_busy));
    endtask

    task automatic set(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia, input logic fl);
        rs_addr = {a1, a0};
        wb_en = we; wb_addr = wa; wb_data = wd;
        issue_en = ie; issue_addr = ia; flush = fl;
        #1;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Preload x5, x7 and mark x9 busy, then reset mid-cycle.
        set(5, 9, 1, 5, 32'hCAFE0005, 1, 9, 0);
        tick("pre1");
        set(5, 9, 1, 7, 32'hCAFE0007, 0, 0, 0);
        tick("pre2");
        set(5, 9, 0, 0, 0, 0, 0, 0);
        check_reads("pre3");
        chk("pre_x5", 64'(rs_data[31:0]), 64'h0000_0000_CAFE_0005);
        chk("pre_x9rdy", 64'(rs_ready[1]), 64'h0);
        #2 reset = 1'b1;
        #1 model_clear();
        chk("rst_busy", 64'(busy_vec), 64'h0);
        chk("rst_data", 64'(rs_data), 64'h0);
        chk("rst_rdy", 64'(rs_ready), 64'h3);
        check_reads("rst");
        tick("rst_edge");
        #2 reset = 1'b0;

        // Plain write/read and writes to x0.
        set(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        tick("w5");
        set(5, 5, 0, 0, 0, 0, 0, 0);
        chk("r5_p0", 64'(rs_data[31:0]), 64'hDEADBEEF);
        chk("r5_p1", 64'(rs_data[63:32]), 64'hDEADBEEF);
        chk("r5_rdy", 64'(rs_ready), 64'h3);
        check_reads("r5");
        set(0, 0, 1, 0, 32'h1234, 0, 0, 0);
        tick("w0");
        set(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0", 64'(rs_data), 64'h0);
        check_reads("r0");

        // Bypass versus stored-only read.
        set(0, 0, 1, 7, 32'h11111111, 0, 0, 0);
        tick("w7a");
        set(7, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0);
        chk("fwd_d", 64'(rs_data[31:0]), 64'hA5A5A5A5);
        chk("fwd_r", 64'(rs_ready[0]), 64'h1);
        chk("nofwd_d", 64'(rs_data_nf[31:0]), 64'h11111111);
        check_reads("fwd");
        tick("w7b");

        // Scoreboard set/clear.
        set(0, 0, 0, 0, 0, 1, 3, 0);
        tick("iss3");
        set(3, 0, 0, 0, 0, 0, 0, 0);
        chk("x3_busyrdy", 64'(rs_ready[0]), 64'h0);
        chk("x3_busybit", 64'(busy_vec[3]), 64'h1);
        check_reads("iss3r");
        set(3, 0, 1, 3, 32'd9, 0, 0, 0);
        chk("x3_wbrdy", 64'(rs_ready[0]), 64'h1);
        chk("x3_wbdat", 64'(rs_data[31:0]), 64'd9);
        chk("x3_nfrdy", 64'(rs_ready_nf[0]), 64'h0);
        check_reads("wb3");
        tick("wb3e");
        chk("x3_clear", 64'(busy_vec[3]), 64'h0);

        // Same-cycle issue and write-back, and issue to x0.
        set(0, 0, 1, 4, 32'h44, 1, 4, 0);
        tick("iw4");
        chk("x4_busy", 64'(busy_vec[4]), 64'h1);
        set(4, 0, 0, 0, 0, 1, 0, 0);
        chk("x4_data", 64'(rs_data[31:0]), 64'h44);
        check_reads("iw4r");
        tick("iss0");
        chk("x0_busy", 64'(busy_vec[0]), 64'h0);

        // Flush wins over issue; write-back still stored.
        set(0, 0, 0, 0, 0, 1, 1, 0);
        tick("i1");
        set(0, 0, 0, 0, 0, 1, 2, 0);
        tick("i2");
        set(0, 0, 0, 0, 0, 1, 3, 0);
        tick("i3");
        set(1, 6, 1, 1, 32'h55, 1, 6, 1);
        check_reads("fl");
        tick("fl_e");
        chk("fl_busy", 64'(busy_vec), 64'h0);
        set(1, 6, 0, 0, 0, 0, 0, 0);
        chk("fl_x1", 64'(rs_data[31:0]), 64'h55);
        check_reads("fl_r");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set(AW'($urandom), AW'($urandom),
                1'($urandom), AW'($urandom), $urandom,
                1'($urandom), AW'($urandom),
                ($urandom_range(0, 15) == 0));
            if (i % 3 == 0)
                rs_addr[AW +: AW] = wb_addr;
            #1;
            check_reads("rnd");
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
